// File: rtl/line_mem_responder_if.sv
// Purpose: request/response bundle between the cache controller (master)
//          and the line memory responder (slave).
// Signals: addr   - line address of the request
//          re/we  - line read (fill) / line write (evict) request
//          wdata  - line to be written
//          rdata  - line read data, valid only while rdy = 1
//          rdy    - one-cycle completion pulse
//          busy   - a request is outstanding
interface line_mem_responder_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LINE_W = 64
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              rdy;
  logic              busy;

  modport master (output addr, re, we, wdata, input rdata, rdy, busy);
  modport slave  (input addr, re, we, wdata, output rdata, rdy, busy);
endinterface

// File: rtl/line_mem_responder.sv
// Purpose: memory-side responder for cache line fills and evictions. Accepts
//          one line read or write at a time, completes it LATENCY cycles after
//          acceptance and signals completion with a one-cycle rdy pulse.
// Ports:   clk  - clock, rising edge
//          rst  - asynchronous active-high reset (storage array is not cleared)
//          bus  - slave side of line_mem_responder_if (addr/re/we/wdata in,
//                 rdata/rdy/busy out, all outputs registered)
module line_mem_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned LATENCY = 4
) (
  input  logic           clk,
  input  logic           rst,
  line_mem_responder_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr_q;
  logic [LINE_W-1:0] r_wdata_q;
  logic              r_op_q;        // 1 = write
  logic              r_rdy;
  logic              r_busy;
  logic [LINE_W-1:0] r_rdata;
  logic [LINE_W-1:0] r_mem [DEPTH];

  logic              w_capture;
  logic              w_op;
  logic [ADDR_W-1:0] w_addr;
  logic [LINE_W-1:0] w_wdata;
  logic              w_mem_we;
  logic              w_rdy_nxt;
  logic              w_busy_nxt;
  logic [LINE_W-1:0] w_rdata_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.re || bus.we)
                w_state_nxt = (LATENCY == 1) ? S_DONE : S_BUSY;
      S_BUSY: if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY = 1 the edge that accepts also completes, so the operation
  // is taken straight from the bus in IDLE rather than from the captured copy.
  assign w_op    = (r_state == S_IDLE) ? bus.we    : r_op_q;
  assign w_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr_q;
  assign w_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata_q;

  // Output / datapath next values
  always_comb begin
    w_capture   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_rdy_nxt   = 1'b0;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_rdata_nxt = '0;
    case (r_state)
      S_IDLE: if (bus.re || bus.we) begin
                w_capture = 1'b1;
                w_cnt_nxt = CNT_W'(LATENCY - 1);
              end
      S_BUSY: w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
    // Edge entering DONE: commit the write or fetch the read line
    if (w_state_nxt == S_DONE && r_state != S_DONE) begin
      w_rdy_nxt = 1'b1;
      if (w_op) w_mem_we    = 1'b1;
      else      w_rdata_nxt = r_mem[w_addr];
    end
  end

  // Captured request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_op_q    <= 1'b0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_rdy   <= w_rdy_nxt;
      r_busy  <= w_busy_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_capture) begin
        r_addr_q  <= bus.addr;
        r_wdata_q <= bus.wdata;
        r_op_q    <= bus.we;
      end
    end
  end

  // Storage array; not reset, and a write is dropped while rst is asserted
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) r_mem[w_addr] <= w_wdata;
  end

  assign bus.rdata = r_rdata;
  assign bus.rdy   = r_rdy;
  assign bus.busy  = r_busy;

endmodule
